// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph table (bit 0 = segment a) and
// the reader's handshake states. Encoder and reader both draw from this table.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index n holds the active-low pattern for hex digit n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } reader_state_t;

    function automatic logic [6:0] glyph_of(input logic [3:0] digit);
        return GLYPHS[digit];
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low segment pattern into a hex digit.
// hit is clear for blank and for any pattern that is not one of the 16 glyphs.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       is_blank,
    output logic [3:0] digit
);

    logic [15:0] match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (pattern == GLYPHS[gi]);
        end
    endgenerate

    // Glyphs are distinct, so at most one match bit is set and OR-ing indices is exact.
    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                digit = digit | 4'(i);
            end
        end
    end

    assign hit      = |match;
    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_reader.sv
// Watches an active-low segment bus, waits for a stable pattern, decodes it and
// offers each newly accepted glyph once on a valid/ready output.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] leds,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_valid,
    output logic       out_err,
    output logic       blank,
    output logic       overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [6:0]    samp_reg;
    logic [6:0]    last_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    digit_reg;
    logic          err_reg;
    logic          blank_reg;
    logic          overrun_reg;
    reader_state_t state_reg;
    reader_state_t state_next;

    logic       dec_hit;
    logic       dec_blank;
    logic [3:0] dec_digit;

    logic accept;
    logic emit;
    logic load;
    logic set_overrun;

    seg7_glyph_decode u_decode (
        .pattern  (samp_reg),
        .hit      (dec_hit),
        .is_blank (dec_blank),
        .digit    (dec_digit)
    );

    assign accept = (cnt_reg == CNT_MAX) && (samp_reg != last_reg);
    assign emit   = accept && !dec_blank;

    always_comb begin
        state_next  = state_reg;
        load        = 1'b0;
        set_overrun = 1'b0;
        case (state_reg)
            IDLE: begin
                if (emit) begin
                    load       = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (out_ready) begin
                    // Consume and reload in the same edge so a back-to-back event has no bubble.
                    load       = emit;
                    state_next = emit ? PEND : IDLE;
                end else if (emit) begin
                    set_overrun = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_reg    <= SEG_BLANK;
            last_reg    <= SEG_BLANK;
            cnt_reg     <= '0;
            digit_reg   <= 4'd0;
            err_reg     <= 1'b0;
            blank_reg   <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            samp_reg <= leds;
            if (leds != samp_reg) begin
                cnt_reg <= CW'(1);
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (accept) begin
                last_reg  <= samp_reg;
                blank_reg <= dec_blank;
            end
            if (load) begin
                digit_reg <= dec_hit ? dec_digit : 4'd0;
                err_reg   <= !dec_hit;
            end
            if (set_overrun) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign out_digit = digit_reg;
    assign out_err   = err_reg;
    assign out_valid = (state_reg == PEND);
    assign blank     = blank_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: stimulus pushes expected {err,digit} events,
// a negedge monitor pops and compares on every valid&ready handshake.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] leds;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_valid;
    logic       out_err;
    logic       blank;
    logic       overrun;

    int tests = 0;
    int fails = 0;

    logic [4:0] exp_q[$];
    logic [6:0] glyph_tab[16];

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .leds      (leds),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_valid (out_valid),
        .out_err   (out_err),
        .blank     (blank),
        .overrun   (overrun)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            logic [4:0] got;
            logic [4:0] want;
            got = {out_err, out_digit};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got err=%0d digit=%0h expected none", out_err, out_digit);
            end else begin
                want = exp_q.pop_front();
                if (got != want) begin
                    fails++;
                    $display("FAIL event: got err=%0d digit=%0h expected err=%0d digit=%0h",
                             got[4], got[3:0], want[4], want[3:0]);
                end else begin
                    $display("[TB] event err=%0d digit=%0h", got[4], got[3:0]);
                end
            end
        end
    end

    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

        // Reset with glyph 2 already on the bus.
        reset = 1'b1; leds = 7'b0100100; out_ready = 1'b1;
        step(3);
        check("rst_valid", out_valid, 0);
        check("rst_digit", out_digit, 0);
        check("rst_err", out_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_blank", blank, 1);
        reset = 1'b0;
        exp_q.push_back({1'b0, 4'h2});
        for (int i = 1; i <= 4; i++) begin
            step(1);
            check($sformatf("lat_idle_e%0d", i), out_valid, 0);
        end
        step(1);
        check("lat_valid_e5", out_valid, 1);
        check("lat_digit", out_digit, 2);
        check("lat_err", out_err, 0);
        check("lat_blank", blank, 0);
        step(1);
        check("drop_after_ready", out_valid, 0);
        step(20);
        check("no_repeat", out_valid, 0);

        // Sweep all glyphs with a free-running consumer.
        for (int d = 0; d < 16; d++) begin
            exp_q.push_back({1'b0, 4'(d)});
            leds = glyph_tab[d];
            step(8);
        end
        check("sweep_drained", exp_q.size(), 0);
        check("sweep_overrun", overrun, 0);

        // Short glitch must not emit or re-emit.
        exp_q.push_back({1'b0, 4'h1});
        leds = 7'b1111001;
        step(8);
        check("glitch_pre_blank", blank, 0);
        leds = 7'b0000000;
        step(2);
        check("glitch_mid_blank", blank, 0);
        leds = 7'b1111001;
        step(10);
        check("glitch_post_blank", blank, 0);
        check("glitch_drained", exp_q.size(), 0);

        // Illegal pattern, then blank.
        exp_q.push_back({1'b1, 4'h0});
        leds = 7'b1010101;
        step(8);
        check("illegal_blank", blank, 0);
        leds = 7'b1111111;
        step(8);
        check("blank_set", blank, 1);
        check("blank_no_event", out_valid, 0);
        check("illegal_drained", exp_q.size(), 0);

        // Stalled consumer: 3 held, 4 dropped, 5 loaded as 3 is consumed.
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'h3});
        leds = glyph_tab[3];
        step(6);
        check("stall_valid3", out_valid, 1);
        check("stall_digit3", out_digit, 3);
        leds = glyph_tab[4];
        step(6);
        check("stall_keep3", out_digit, 3);
        check("stall_overrun", overrun, 1);
        exp_q.push_back({1'b0, 4'h5});
        leds = glyph_tab[5];
        step(4);
        out_ready = 1'b1;
        check("b2b_valid_before", out_valid, 1);
        step(1);
        check("b2b_valid_after", out_valid, 1);
        check("b2b_digit5", out_digit, 5);
        step(1);
        check("b2b_done", out_valid, 0);
        check("overrun_sticky", overrun, 1);

        // Reset while pending with 7: event lost, then re-emitted once.
        out_ready = 1'b0;
        leds = glyph_tab[7];
        step(6);
        check("pend7_valid", out_valid, 1);
        reset = 1'b1;
        step(1);
        check("midrst_valid", out_valid, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_blank", blank, 1);
        step(1);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 4'h7});
        step(4);
        check("re7_early", out_valid, 0);
        step(1);
        check("re7_valid", out_valid, 1);
        check("re7_digit", out_digit, 7);
        step(10);
        check("final_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
